i2c_slave: RTL

- I2C target (slave) responder: the bus-side counterpart of the team's i2c_master.
- Recognises START/STOP, matches a 7-bit address and ACKs it.
- Write transfers: delivers received bytes to a FIFO push port.
- Read transfers: pulls bytes from a FIFO (first-word fall-through) pop port.
- Top level wraps scl/sda pins in SB_IO; this block sees plain in/out signals and never drives SCL (no clock stretching).

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_slave_if.sv | 30 +++
 rtl/i2c_bus_cond.sv | 59 +++++
 rtl/i2c_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared I2C state encodings, bus-condition codes, ACK levels
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package i2c_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [ST_W-1:0] ST_ADDR     = 4'd1;
  localparam logic [ST_W-1:0] ST_ADDR_ACK = 4'd2;
  localparam logic [ST_W-1:0] ST_RX       = 4'd3;
  localparam logic [ST_W-1:0] ST_RX_ACK   = 4'd4;
  localparam logic [ST_W-1:0] ST_TX       = 4'd5;
  localparam logic [ST_W-1:0] ST_TX_ACK   = 4'd6;
  localparam logic [ST_W-1:0] ST_WAIT     = 4'd7;

  localparam logic [1:0] COND_NONE  = 2'd0;
  localparam logic [1:0] COND_START = 2'd1;
  localparam logic [1:0] COND_STOP  = 2'd2;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_if.sv
// ============================================================================
// i2c_slave_if : pad and FIFO-side signals of the I2C target
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       general_call;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy, general_call
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy, general_call
  );
endinterface

`default_nettype wire

// File: rtl/i2c_bus_cond.sv
// ============================================================================
// i2c_bus_cond : SCL/SDA synchroniser with SCL edge and START/STOP detection
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic [1:0] o_cond
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_start;
  logic                   w_stop;

  // Idle bus is high on both lines, so reset there to avoid a false START
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_start = w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d &  w_sda;

  assign o_sda      = w_sda;
  assign o_scl_rise =  w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl &  r_scl_d;
  assign o_cond     = w_start ? COND_START : (w_stop ? COND_STOP : COND_NONE);

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
// i2c_slave : I2C target with 7-bit address match, FIFO push/pop data ports
// Rev 1.0  -- optional general call via `define I2C_SLAVE_GENERAL_CALL_EN
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2c_slave_if.slave  bus
);

  logic            w_sda;
  logic            w_rise;
  logic            w_fall;
  logic [1:0]      w_cond;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic [7:0]      r_shift;
  logic [3:0]      r_cnt;
  logic            r_rw;
  logic            r_acked;
  logic            r_sda_oe;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_busy;
  logic            r_gc;

  logic [7:0]      w_shift_nxt;
  logic [3:0]      w_cnt_nxt;
  logic            w_rw_nxt;
  logic            w_acked_nxt;
  logic            w_oe_nxt;
  logic [7:0]      w_rx_data_nxt;
  logic            w_rx_valid_nxt;
  logic            w_busy_nxt;
  logic            w_gc_nxt;
  logic            w_tx_req;
  logic            w_gc_hit;
  logic            w_addr_hit;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (bus.scl_in),
    .i_sda      (bus.sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_cond     (w_cond)
  );

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign w_gc_hit = (r_shift == 8'h00);
`else
  assign w_gc_hit = 1'b0;
`endif
  assign w_addr_hit = (r_shift[7:1] == SLAVE_ADDR) || w_gc_hit;

  always_ff @(posedge clk) begin : p_state
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    if (w_cond == COND_START)      w_state_nxt = ST_ADDR;
    else if (w_cond == COND_STOP)  w_state_nxt = ST_IDLE;
    else begin
      case (r_state)
        ST_ADDR:     if (w_fall && r_cnt == 4'd8) w_state_nxt = w_addr_hit ? ST_ADDR_ACK : ST_WAIT;
        ST_ADDR_ACK: if (w_fall) w_state_nxt = r_rw ? ST_TX : ST_RX;
        ST_RX:       if (w_fall && r_cnt == 4'd8) w_state_nxt = ST_RX_ACK;
        ST_RX_ACK:   if (w_fall) w_state_nxt = ST_RX;
        ST_TX:       if (w_fall && r_cnt == 4'd7) w_state_nxt = ST_TX_ACK;
        ST_TX_ACK: begin
          if (w_rise && w_sda == NACK)  w_state_nxt = ST_WAIT;
          else if (w_fall && r_acked)   w_state_nxt = ST_TX;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : p_out
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_rw_nxt       = r_rw;
    w_acked_nxt    = r_acked;
    w_oe_nxt       = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_gc_nxt       = r_gc;
    w_tx_req       = 1'b0;
    if (w_cond != COND_NONE) begin
      w_cnt_nxt  = 4'd0;
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
      w_gc_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == 4'd8) begin
            w_cnt_nxt  = 4'd0;
            w_oe_nxt   = w_addr_hit;
            w_busy_nxt = w_addr_hit;
            w_gc_nxt   = w_gc_hit;
            w_rw_nxt   = r_shift[0];
          end
        end
        ST_ADDR_ACK: if (w_fall) begin
          w_cnt_nxt = 4'd0;
          if (r_rw) begin
            w_tx_req    = 1'b1;
            w_shift_nxt = bus.tx_data;
            w_oe_nxt    = ~bus.tx_data[7];
          end else begin
            w_oe_nxt = 1'b0;
          end
        end
        ST_RX: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == 4'd8) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_oe_nxt       = 1'b1;
            w_cnt_nxt      = 4'd0;
          end
        end
        ST_RX_ACK: if (w_fall) w_oe_nxt = 1'b0;
        // Bit 7 is already on the line when TX is entered; shift out 6..0, then release
        ST_TX: if (w_fall) begin
          if (r_cnt == 4'd7) begin
            w_oe_nxt    = 1'b0;
            w_acked_nxt = 1'b0;
          end else begin
            w_oe_nxt    = ~r_shift[6];
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
        ST_TX_ACK: begin
          if (w_rise) begin
            w_acked_nxt = (w_sda == ACK);
          end else if (w_fall && r_acked) begin
            w_tx_req    = 1'b1;
            w_shift_nxt = bus.tx_data;
            w_oe_nxt    = ~bus.tx_data[7];
            w_cnt_nxt   = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin : p_data
    if (!rst) begin
      r_shift    <= 8'h00;
      r_cnt      <= 4'd0;
      r_rw       <= 1'b0;
      r_acked    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_gc       <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_acked    <= w_acked_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_gc       <= w_gc_nxt;
    end
  end

  assign bus.sda_oe       = r_sda_oe;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.tx_req       = w_tx_req;
  assign bus.busy         = r_busy;
  assign bus.general_call = r_gc;

endmodule

`default_nettype wire
